game_state_ctrl: RTL

- Top-level game sequencer that produces the 4-bit screen/stage `state` and the HUD/object status flags consumed by the display stage (`key_find`, `heart`, `todo`, `play_valid`, `isLocked`).
- Sits directly upstream of the display path. It takes debounced single-cycle button pulses and gameplay events (hit, key pickup, door reached) and advances the screen state machine.
- Owns the auto-advance hold timer on success screens.

---
 rtl/game_pkg.sv | 32 +++
 rtl/game_state_ctrl_if.sv | 32 +++
 rtl/game_state_ctrl_hold_timer.sv | 50 +++++
 rtl/game_state_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game constants: screen/stage codes, HUD objective codes, default lives.
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a. Imported by the sequencer and by the display path.
package game_pkg;

   typedef logic [3:0] state_t;
   typedef logic [1:0] heart_t;
   typedef logic [1:0] todo_t;

   // Screen/stage codes as seen by the display path
   localparam logic [3:0] ST_TITLE    = 4'd0;
   localparam logic [3:0] ST_STAFF    = 4'd1;
   localparam logic [3:0] ST_STAGE1   = 4'd2;
   localparam logic [3:0] ST_SUCCESS1 = 4'd3;
   localparam logic [3:0] ST_STAGE2   = 4'd4;
   localparam logic [3:0] ST_SUCCESS2 = 4'd5;
   localparam logic [3:0] ST_STAGE3   = 4'd6;
   localparam logic [3:0] ST_SUCCESS3 = 4'd7;
   localparam logic [3:0] ST_FAIL     = 4'd8;

   // HUD objective shown during play
   localparam logic [1:0] TODO_NONE = 2'd0;
   localparam logic [1:0] TODO_KEY  = 2'd1;
   localparam logic [1:0] TODO_DOOR = 2'd2;

   localparam int unsigned MAX_HEART_DEF = 3;

   function automatic logic is_stage(input state_t s);
      return (s == ST_STAGE1) || (s == ST_STAGE2) || (s == ST_STAGE3);
   endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// Event/status bundle between the gameplay front end and the game sequencer.
// Latency: n/a (wires only). Backpressure: none, events are single-cycle pulses/levels.
// Ports: master = event source / HUD consumer, slave = game_state_ctrl.
interface game_state_ctrl_if;
   import game_pkg::*;

   // events into the sequencer
   logic   start_btn;
   logic   staff_btn;
   logic   player_hit;
   logic   key_picked;
   logic   door_reached;

   // registered status out of the sequencer
   state_t state;
   heart_t heart;
   logic   key_find;
   logic   isLocked;
   todo_t  todo;
   logic   play_valid;

   modport master (
      output start_btn, staff_btn, player_hit, key_picked, door_reached,
      input  state, heart, key_find, isLocked, todo, play_valid
   );

   modport slave (
      input  start_btn, staff_btn, player_hit, key_picked, door_reached,
      output state, heart, key_find, isLocked, todo, play_valid
   );

endinterface

// File: rtl/game_state_ctrl_hold_timer.sv
// Generic hold timer: up-counter with terminal pulse, or loadable down-counter with busy flag.
// Latency: tc_o/busy_o are combinational from the count register; count updates one edge later.
// Backpressure: none. Ports: clk, rst (async active-low), clr_i, en_i, load_i -> tc_o, busy_o.
module hold_timer #(
   parameter int unsigned TERM = 16,
   parameter bit          DOWN = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   input  logic load_i,
   output logic tc_o,
   output logic busy_o
);

   localparam int unsigned    W    = (TERM < 2) ? 1 : $clog2(TERM);
   localparam logic [W-1:0]   LAST = W'(TERM - 1);
   localparam logic [W-1:0]   ONE  = W'(1);

   logic [W-1:0] cnt_q, cnt_d;

   // clear dominates load, load dominates counting
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (DOWN) begin
         if (load_i) begin
            cnt_d = LAST;
         end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
         end
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);
   assign tc_o   = en_i && (DOWN ? (cnt_q == ONE) : (cnt_q == LAST));

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: screen/stage state machine plus HUD flags (lives, key, lock, objective).
// Latency: every input affects the registered outputs one clock edge after it is sampled.
// Backpressure: none; buttons and events are pulses taken as they come.
// Ports: clk, rst (async active-low), bus (game_state_ctrl_if.slave).
// Optional build macro GAME_INVUL_EN adds a post-hit invulnerability window.
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int unsigned MAX_HEART    = MAX_HEART_DEF,
   parameter int unsigned SUCCESS_HOLD = 100_000_000,
   parameter int unsigned INVUL_CYCLES = 50_000_000
) (
   input logic              clk,
   input logic              rst,
   game_state_ctrl_if.slave bus
);

   localparam heart_t HEART_INIT = heart_t'(MAX_HEART);

   state_t state_q,      state_d;
   heart_t heart_q,      heart_d;
   logic   key_find_q,   key_find_d;
   logic   is_locked_q,  is_locked_d;
   todo_t  todo_q,       todo_d;
   logic   play_valid_q, play_valid_d;

   logic   hit_ok;
   logic   illegal;
   logic   hold_en;
   logic   hold_clr;
   logic   hold_tc;
   logic   hold_busy_unused;

   // ---------------- screen state machine ----------------
   always_comb begin
      state_d    = state_q;
      heart_d    = heart_q;
      key_find_d = key_find_q;
      illegal    = 1'b0;

      case (state_q)
         ST_TITLE: begin
            if (bus.start_btn) begin
               state_d = ST_STAGE1;
               heart_d = HEART_INIT;
            end else if (bus.staff_btn) begin
               state_d = ST_STAFF;
            end
         end

         ST_STAFF, ST_SUCCESS3, ST_FAIL: begin
            if (bus.start_btn) begin
               state_d = ST_TITLE;
            end
         end

         ST_STAGE1, ST_STAGE2, ST_STAGE3: begin
            if (bus.key_picked) begin
               key_find_d = 1'b1;
            end
            if (hit_ok && (heart_q <= 2'd1)) begin
               // fatal hit beats a door success in the same cycle
               heart_d = '0;
               state_d = ST_FAIL;
            end else begin
               if (hit_ok) begin
                  heart_d = heart_q - 2'd1;
               end
               // registered key flag: a pickup in this very cycle cannot open the door yet
               if (bus.door_reached && key_find_q) begin
                  state_d = state_q + 4'd1;   // STAGEn -> SUCCESSn is the next code
               end
            end
         end

         ST_SUCCESS1, ST_SUCCESS2: begin
            if (bus.start_btn || hold_tc) begin
               state_d = state_q + 4'd1;      // SUCCESSn -> STAGEn+1
            end
         end

         default: begin
            // unused codes recover to TITLE without touching anything else
            state_d = ST_TITLE;
            illegal = 1'b1;
         end
      endcase

      if (is_stage(state_d) && (state_d != state_q)) begin
         key_find_d = 1'b0;
      end
   end

   // HUD flags follow the next-state values so they line up with state
   always_comb begin
      is_locked_d  = is_locked_q;
      todo_d       = todo_q;
      play_valid_d = play_valid_q;
      if (!illegal) begin
         is_locked_d  = !key_find_d;
         play_valid_d = is_stage(state_d);
         if (!is_stage(state_d)) begin
            todo_d = TODO_NONE;
         end else if (key_find_d) begin
            todo_d = TODO_DOOR;
         end else begin
            todo_d = TODO_KEY;
         end
      end
   end

   // ---------------- success-screen auto-advance ----------------
   assign hold_en  = (state_q == ST_SUCCESS1) || (state_q == ST_SUCCESS2);
   assign hold_clr = (state_d != state_q);

   hold_timer #(
      .TERM (SUCCESS_HOLD),
      .DOWN (1'b0)
   ) u_hold (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (hold_clr),
      .en_i   (hold_en),
      .load_i (1'b0),
      .tc_o   (hold_tc),
      .busy_o (hold_busy_unused)
   );

   // ---------------- hit filtering ----------------
`ifdef GAME_INVUL_EN
   logic invul_busy;
   logic invul_tc_unused;
   logic hit_applied;
   logic leave_stage;

   assign leave_stage = is_stage(state_q) && !is_stage(state_d);
   assign hit_ok      = bus.player_hit && !invul_busy;
   assign hit_applied = hit_ok && is_stage(state_q);

   hold_timer #(
      .TERM (INVUL_CYCLES),
      .DOWN (1'b1)
   ) u_invul (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (leave_stage),
      .en_i   (1'b1),
      .load_i (hit_applied),
      .tc_o   (invul_tc_unused),
      .busy_o (invul_busy)
   );
`else
   localparam int unsigned invul_cycles_unused = INVUL_CYCLES;
   assign hit_ok = bus.player_hit;
`endif

   // ---------------- registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_TITLE;
         heart_q      <= HEART_INIT;
         key_find_q   <= 1'b0;
         is_locked_q  <= 1'b1;
         todo_q       <= TODO_NONE;
         play_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         heart_q      <= heart_d;
         key_find_q   <= key_find_d;
         is_locked_q  <= is_locked_d;
         todo_q       <= todo_d;
         play_valid_q <= play_valid_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.heart      = heart_q;
   assign bus.key_find   = key_find_q;
   assign bus.isLocked   = is_locked_q;
   assign bus.todo       = todo_q;
   assign bus.play_valid = play_valid_q;

endmodule
